// File: rtl/mdu_sched.sv
// Multiply/divide scheduler: owns HI/LO, models multi-cycle MDU latency with a
// busy counter and raises the D-stage stall for HI/LO hazards.
module mdu_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_mdu_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_mdu_use,
  output logic        busy,
  output logic        stall_D,
  output logic [31:0] E_hilo_out,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [1:0]  dbg_state
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic            r_no_commit;

  logic            w_start;
  logic [63:0]     w_prod_s, w_prod_u;
  logic            w_rs_neg, w_rt_neg;
  logic [31:0]     w_abs_rs, w_abs_rt, w_abs_rt_safe, w_rt_safe;
  logic [31:0]     w_uq, w_ur, w_sq, w_sr, w_q, w_r;

  assign w_start = (E_mdu_op >= OP_MULT) && (E_mdu_op <= OP_DIVU) && (r_state == S_IDLE);

  // Low 64 bits of the sign-extended product equal the signed 64-bit product.
  assign w_prod_s = {{32{E_rs[31]}}, E_rs} * {{32{E_rt[31]}}, E_rt};
  assign w_prod_u = {32'd0, E_rs} * {32'd0, E_rt};

  // Signed division via magnitudes: 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_rs_neg      = E_rs[31];
  assign w_rt_neg      = E_rt[31];
  assign w_abs_rs      = w_rs_neg ? (32'd0 - E_rs) : E_rs;
  assign w_abs_rt      = w_rt_neg ? (32'd0 - E_rt) : E_rt;
  assign w_abs_rt_safe = (w_abs_rt == 32'd0) ? 32'd1 : w_abs_rt;
  assign w_rt_safe     = (E_rt == 32'd0) ? 32'd1 : E_rt;
  assign w_uq          = w_abs_rs / w_abs_rt_safe;
  assign w_ur          = w_abs_rs % w_abs_rt_safe;
  assign w_sq          = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_uq) : w_uq;
  assign w_sr          = w_rs_neg ? (32'd0 - w_ur) : w_ur;
  assign w_q           = (E_mdu_op == OP_DIV) ? w_sq : (E_rs / w_rt_safe);
  assign w_r           = (E_mdu_op == OP_DIV) ? w_sr : (E_rs % w_rt_safe);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_pend_hi   <= '0;
      r_pend_lo   <= '0;
      r_no_commit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            if (E_mdu_op == OP_MULT || E_mdu_op == OP_MULTU) begin
              {r_pend_hi, r_pend_lo} <= (E_mdu_op == OP_MULT) ? w_prod_s : w_prod_u;
              r_no_commit <= 1'b0;
              r_cnt       <= CW'(MULT_CYCLES - 1);
              r_state     <= S_MUL;
            end else begin
              r_pend_hi   <= w_r;
              r_pend_lo   <= w_q;
              r_no_commit <= (E_rt == 32'd0);
              r_cnt       <= CW'(DIV_CYCLES - 1);
              r_state     <= S_DIV;
            end
          end else if (E_mdu_op == OP_MTHI) begin
            r_hi <= E_rs;
          end else if (E_mdu_op == OP_MTLO) begin
            r_lo <= E_rs;
          end
        end
        S_MUL, S_DIV: begin
          if (r_cnt == '0) begin
            if (!r_no_commit) begin
              r_hi <= r_pend_hi;
              r_lo <= r_pend_lo;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    E_hilo_out = 32'd0;
    if (E_mdu_op == OP_MFHI)      E_hilo_out = r_hi;
    else if (E_mdu_op == OP_MFLO) E_hilo_out = r_lo;
  end

  assign busy      = (r_state != S_IDLE);
  assign stall_D   = D_mdu_use & (busy | w_start);
  assign HI        = r_hi;
  assign LO        = r_lo;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: a cycle-indexed model of HI/LO and busy windows checked
// every cycle, plus directed scenarios with hand-computed literal results.
module tb_mdu_sched;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  E_mdu_op;
  logic [31:0] E_rs, E_rt;
  logic        D_mdu_use;
  logic        busy, stall_D;
  logic [31:0] E_hilo_out, HI, LO;
  logic [1:0]  dbg_state;
  logic        busy1, stall1;
  logic [31:0] hilo1, hi1, lo1;
  logic [1:0]  dbg1;

  mdu_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) u_dut (
    .clk(clk), .reset(reset), .E_mdu_op(E_mdu_op), .E_rs(E_rs), .E_rt(E_rt),
    .D_mdu_use(D_mdu_use), .busy(busy), .stall_D(stall_D), .E_hilo_out(E_hilo_out),
    .HI(HI), .LO(LO), .dbg_state(dbg_state)
  );

  // Minimum-latency instance sharing the same inputs.
  mdu_sched #(.MULT_CYCLES(1), .DIV_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset), .E_mdu_op(E_mdu_op), .E_rs(E_rs), .E_rt(E_rt),
    .D_mdu_use(D_mdu_use), .busy(busy1), .stall_D(stall1), .E_hilo_out(hilo1),
    .HI(hi1), .LO(lo1), .dbg_state(dbg1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Busy is the window of edges [start_edge, commit_edge); results land at commit_edge.
  int          edge_no = 0;
  int          commit_edge = 0;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_nowrite = 0;
  bit          m_valid = 0;

  task automatic model_start();
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     prod;
    int              a, b;
    p_nowrite = 0;
    case (E_mdu_op)
      4'd1: begin
        sa = longint'($signed(E_rs)); sb = longint'($signed(E_rt));
        prod = sa * sb; {p_hi, p_lo} = prod; commit_edge = edge_no + MC;
      end
      4'd2: begin
        ua = E_rs; ub = E_rt;
        prod = ua * ub; {p_hi, p_lo} = prod; commit_edge = edge_no + MC;
      end
      4'd3: begin
        a = $signed(E_rs); b = $signed(E_rt);
        if (b == 0) p_nowrite = 1;
        else if (E_rs == 32'h8000_0000 && E_rt == 32'hFFFF_FFFF) begin
          p_lo = 32'h8000_0000; p_hi = 32'd0;
        end else begin
          p_lo = a / b; p_hi = a % b;
        end
        commit_edge = edge_no + DC;
      end
      default: begin
        if (E_rt == 32'd0) p_nowrite = 1;
        else begin p_lo = E_rs / E_rt; p_hi = E_rs % E_rt; end
        commit_edge = edge_no + DC;
      end
    endcase
  endtask

  always @(posedge clk) begin
    bit was_busy;
    was_busy = (edge_no < commit_edge);
    edge_no++;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; commit_edge = 0; m_valid = 1;
    end else begin
      if (was_busy && edge_no == commit_edge && !p_nowrite) begin
        m_hi = p_hi; m_lo = p_lo;
      end
      if (!was_busy) begin
        if (E_mdu_op >= 4'd1 && E_mdu_op <= 4'd4) model_start();
        else if (E_mdu_op == 4'd7) m_hi = E_rs;
        else if (E_mdu_op == 4'd8) m_lo = E_rs;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    bit e_busy, e_start;
    logic [31:0] e_hilo;
    if (m_valid) begin
      e_busy  = (edge_no < commit_edge);
      e_start = !e_busy && E_mdu_op >= 4'd1 && E_mdu_op <= 4'd4;
      e_hilo  = (E_mdu_op == 4'd5) ? m_hi : (E_mdu_op == 4'd6) ? m_lo : 32'd0;
      check("busy", {31'd0, busy}, {31'd0, e_busy});
      check("stall_D", {31'd0, stall_D}, {31'd0, D_mdu_use & (e_busy | e_start)});
      check("E_hilo_out", E_hilo_out, e_hilo);
      check("HI", HI, m_hi);
      check("LO", LO, m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic duse);
    @(posedge clk); #1;
    E_mdu_op = op; E_rs = rs; E_rt = rt; D_mdu_use = duse;
  endtask

  // Advance past the start cycle and count busy cycles; ends at the first idle cycle's negedge.
  task automatic wait_done(output int nb);
    nb = 0;
    step(4'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) return;
      nb++;
      @(posedge clk);
    end
    check("busy_timeout", 32'd1, 32'd0);
  endtask

  // Hold an MDU op in D while stalled, bubbling E; returns the number of stalled cycles.
  task automatic count_stall(output int sc);
    sc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!stall_D) return;
      sc++;
      @(posedge clk); #1;
      E_mdu_op = 4'd0;
    end
    check("stall_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int nb, sc;
    reset = 1'b1; E_mdu_op = 4'd0; E_rs = 32'd0; E_rt = 32'd0; D_mdu_use = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_HI", HI, 32'd0);
    check("rst_LO", LO, 32'd0);

    // MULT -3 * 7
    step(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_done(nb);
    check("mult_busy_len", nb, MC);
    check("mult_HI", HI, 32'hFFFF_FFFF);
    check("mult_LO", LO, 32'hFFFF_FFEB);

    // MULTU 0xFFFFFFFF * 2, then MFLO
    step(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    wait_done(nb);
    check("multu_busy_len", nb, MC);
    check("multu_HI", HI, 32'h0000_0001);
    check("multu_LO", LO, 32'hFFFF_FFFE);
    step(4'd6, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("mflo_out", E_hilo_out, 32'hFFFF_FFFE);
    step(4'd5, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("mfhi_out", E_hilo_out, 32'h0000_0001);

    // DIV -7 / 2
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_done(nb);
    check("div_busy_len", nb, DC);
    check("div_LO", LO, 32'hFFFF_FFFD);
    check("div_HI", HI, 32'hFFFF_FFFF);

    // MTHI/MTLO then DIVU by zero: HI/LO retained
    step(4'd7, 32'h0000_1234, 32'd0, 1'b0);
    step(4'd8, 32'h0000_5678, 32'd0, 1'b0);
    step(4'd4, 32'd7, 32'd0, 1'b0);
    wait_done(nb);
    check("divu0_busy_len", nb, DC);
    check("divu0_HI", HI, 32'h0000_1234);
    check("divu0_LO", LO, 32'h0000_5678);

    // Signed overflow case
    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done(nb);
    check("divovf_LO", LO, 32'h8000_0000);
    check("divovf_HI", HI, 32'd0);

    // DIVU 100 / 7
    step(4'd4, 32'd100, 32'd7, 1'b0);
    wait_done(nb);
    check("divu_LO", LO, 32'd14);
    check("divu_HI", HI, 32'd2);

    // Invalid op codes do nothing
    step(4'd9, 32'hDEAD_BEEF, 32'd1, 1'b0);
    @(negedge clk);
    check("op9_hilo", E_hilo_out, 32'd0);
    step(4'd15, 32'hDEAD_BEEF, 32'd1, 1'b0);
    @(negedge clk);
    check("op15_busy", {31'd0, busy}, 32'd0);
    check("op15_HI", HI, 32'd2);

    // MULT with MFHI held in D
    step(4'd1, 32'd3, 32'd4, 1'b1);
    count_stall(sc);
    check("stall_len", sc, MC + 1);
    check("stall_rel_busy", {31'd0, busy}, 32'd0);
    check("stall_rel_LO", LO, 32'd12);
    step(4'd5, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("mfhi_after_stall", E_hilo_out, 32'd0);

    // Non-MDU instruction in D never stalls, even while busy
    step(4'd1, 32'd2, 32'd2, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("no_stall_busy", {31'd0, stall_D}, 32'd0);
    wait_done(nb);

    // Single-cycle multiply instance
    step(4'd1, 32'd5, 32'd6, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("mc1_busy", {31'd0, busy1}, 32'd1);
    step(4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("mc1_idle", {31'd0, busy1}, 32'd0);
    check("mc1_LO", lo1, 32'd30);
    wait_done(nb);

    // Reset on busy cycle 4 of a DIV abandons it
    step(4'd7, 32'h0000_ABCD, 32'd0, 1'b0);
    step(4'd3, 32'd100, 32'd7, 1'b0);
    repeat (3) step(4'd0, 32'd0, 32'd0, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_HI", HI, 32'd0);
    check("rst_mid_LO", LO, 32'd0);
    repeat (12) step(4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("rst_nocommit_HI", HI, 32'd0);
    check("rst_nocommit_LO", LO, 32'd0);

    // Back-to-back MULT then DIV held in D
    step(4'd1, 32'd6, 32'd7, 1'b1);
    count_stall(sc);
    check("b2b_stall_len", sc, MC + 1);
    check("b2b_mult_LO", LO, 32'd42);
    step(4'd3, 32'hFFFF_FF9C, 32'd7, 1'b0);
    @(negedge clk);
    check("b2b_div_start_idle", {31'd0, busy}, 32'd0);
    wait_done(nb);
    check("b2b_div_len", nb, DC);
    check("b2b_LO", LO, 32'hFFFF_FFF2);
    check("b2b_HI", HI, 32'hFFFF_FFFE);

    repeat (2) step(4'd0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
